// File: rtl/fpga_board_top_if.sv
// Board pin bundle for the CPU lab FPGA top: buttons, switches, LEDs and
// the multiplexed 4-digit 7-segment display.
interface fpga_board_top_if;
    logic       BTND;
    logic       SW0;
    logic       SW1;
    logic [7:0] LED;
    logic [7:0] Cathodes;
    logic [3:0] AN;

    // The board/bench side drives the buttons and switches and watches the outputs
    modport master (
        output BTND,
        output SW0,
        output SW1,
        input  LED,
        input  Cathodes,
        input  AN
    );

    // The design side reads the buttons and switches and drives the outputs
    modport slave (
        input  BTND,
        input  SW0,
        input  SW1,
        output LED,
        output Cathodes,
        output AN
    );
endinterface

// File: rtl/fpga_board_top.sv
// Board-level top for the CPU lab FPGA.
// A free-running step engine advances pc, cnt and acc once every STEP_DIV
// clocks, unless the hold button is pressed. pc is shown on the LEDs. A
// switch-selected 16-bit value is shown on a 4-digit multiplexed hex display,
// and each digit is lit for SCAN_DIV clocks. BTNU is a synchronous reset.
module fpga_board_top #(
    parameter int STEP_DIV = 4,
    parameter int SCAN_DIV = 16
) (
    input  logic              sysclk,
    input  logic              BTNU,
    fpga_board_top_if.slave   pins
);

    localparam int STEP_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_DIV - 1);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

    logic [7:0]        pc;
    logic [15:0]       cnt;
    logic [15:0]       acc;
    logic [STEP_W-1:0] step_ctr;
    logic [SCAN_W-1:0] scan_ctr;
    logic [1:0]        dig;

    logic              step_fire;
    logic [15:0]       disp_value;
    logic [3:0]        nibble;
    logic [7:0]        seg_code;
    logic [3:0]        an_code;

    // Hex digit to active-low segment pattern {dp,g,f,e,d,c,b,a}, dp kept off
    function automatic logic [7:0] seg(input logic [3:0] hex);
        logic [7:0] code;
        case (hex)
            4'h0:    code = 8'hC0;
            4'h1:    code = 8'hF9;
            4'h2:    code = 8'hA4;
            4'h3:    code = 8'hB0;
            4'h4:    code = 8'h99;
            4'h5:    code = 8'h92;
            4'h6:    code = 8'h82;
            4'h7:    code = 8'hF8;
            4'h8:    code = 8'h80;
            4'h9:    code = 8'h90;
            4'hA:    code = 8'h88;
            4'hB:    code = 8'h83;
            4'hC:    code = 8'hC6;
            4'hD:    code = 8'hA1;
            4'hE:    code = 8'h86;
            default: code = 8'h8E;
        endcase
        return code;
    endfunction

    // A step fires on the edge where the divider is at its last count and not held
    assign step_fire = !pins.BTND && (step_ctr == STEP_LAST);

    // Step engine: the divider advances while running, and pc/cnt/acc update on each step
    always_ff @(posedge sysclk) begin
        if (BTNU) begin
            step_ctr <= '0;
            pc       <= '0;
            cnt      <= '0;
            acc      <= '0;
        end else if (!pins.BTND) begin
            if (step_fire) begin
                step_ctr <= '0;
                pc       <= pc + 8'd1;
                cnt      <= cnt + 16'd1;
                acc      <= acc + cnt + 16'd1;
            end else begin
                step_ctr <= step_ctr + STEP_W'(1);
            end
        end
    end

    // Display scanner: it keeps running during hold and moves to the next digit every SCAN_DIV clocks
    always_ff @(posedge sysclk) begin
        if (BTNU) begin
            scan_ctr <= '0;
            dig      <= '0;
        end else if (scan_ctr == SCAN_LAST) begin
            scan_ctr <= '0;
            dig      <= dig + 2'd1;
        end else begin
            scan_ctr <= scan_ctr + SCAN_W'(1);
        end
    end

    // The switch-selected display value is picked combinationally so a switch change shows up at once
    always_comb begin
        disp_value = acc;
        case ({pins.SW1, pins.SW0})
            2'b00:   disp_value = acc;
            2'b01:   disp_value = cnt;
            2'b10:   disp_value = {8'h00, pc};
            default: disp_value = {cnt[7:0], pc};
        endcase
    end

    // Choose the nibble and the active-low anode for the digit that is lit now
    always_comb begin
        nibble  = disp_value[3:0];
        an_code = 4'b1110;
        case (dig)
            2'd0: begin
                nibble  = disp_value[3:0];
                an_code = 4'b1110;
            end
            2'd1: begin
                nibble  = disp_value[7:4];
                an_code = 4'b1101;
            end
            2'd2: begin
                nibble  = disp_value[11:8];
                an_code = 4'b1011;
            end
            default: begin
                nibble  = disp_value[15:12];
                an_code = 4'b0111;
            end
        endcase
        seg_code = seg(nibble);
    end

    assign pins.LED      = pc;
    assign pins.AN       = an_code;
    assign pins.Cathodes = seg_code;

endmodule

// File: tb/tb_fpga_board_top.sv
// Self-checking bench for fpga_board_top. A reference model tracks how many
// clocks the engine has run and how many clocks the scanner has run. From
// those counts it derives the step count, pc/cnt/acc (closed form) and the
// lit digit, and it checks the board pins every cycle.
module tb_fpga_board_top;

    localparam int STEP_DIV = 4;
    localparam int SCAN_DIV = 16;

    localparam logic [7:0] SEG_TAB [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };
    localparam logic [3:0] AN_TAB [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    logic sysclk = 1'b0;
    logic btnu   = 1'b1;

    fpga_board_top_if bus();

    fpga_board_top #(
        .STEP_DIV(STEP_DIV),
        .SCAN_DIV(SCAN_DIV)
    ) dut (
        .sysclk(sysclk),
        .BTNU  (btnu),
        .pins  (bus)
    );

    always #5 sysclk = ~sysclk;

    int total = 0;
    int bad   = 0;

    int run_cycles  = 0;
    int scan_cycles = 0;

    function automatic int model_steps();
        return run_cycles / STEP_DIV;
    endfunction

    function automatic logic [15:0] model_value(input logic [1:0] sel);
        longint k;
        logic [15:0] pc16, cnt16, acc16;
        k     = longint'(model_steps());
        pc16  = 16'(k % 256);
        cnt16 = 16'(k % 65536);
        acc16 = 16'(((k * (k + 1)) / 2) % 65536);
        case (sel)
            2'b00:   return acc16;
            2'b01:   return cnt16;
            2'b10:   return pc16;
            default: return {cnt16[7:0], pc16[7:0]};
        endcase
    endfunction

    function automatic int model_dig();
        return (scan_cycles / SCAN_DIV) % 4;
    endfunction

    function automatic logic [7:0] model_led();
        return 8'(model_steps() % 256);
    endfunction

    task automatic applyStimulus(input logic rst_in, input logic hold, input logic [1:0] sel);
        btnu    = rst_in;
        bus.BTND = hold;
        bus.SW1  = sel[1];
        bus.SW0  = sel[0];
    endtask

    task automatic tick();
        @(posedge sysclk);
        if (btnu) begin
            run_cycles  = 0;
            scan_cycles = 0;
        end else begin
            if (!bus.BTND) run_cycles++;
            scan_cycles++;
        end
        #1;
    endtask

    task automatic checkOutput(input string tag);
        logic [15:0] val;
        logic [7:0]  exp_led, exp_cath;
        logic [3:0]  exp_an;
        int          d;
        d        = model_dig();
        val      = model_value({bus.SW1, bus.SW0});
        exp_led  = model_led();
        exp_an   = AN_TAB[d];
        exp_cath = SEG_TAB[(val >> (4 * d)) & 16'hF];
        total++;
        assert (bus.LED === exp_led) else begin
            bad++;
            $error("FAIL %s led got=%h want=%h", tag, bus.LED, exp_led);
        end
        total++;
        assert (bus.AN === exp_an) else begin
            bad++;
            $error("FAIL %s an got=%b want=%b", tag, bus.AN, exp_an);
        end
        total++;
        assert (bus.Cathodes === exp_cath) else begin
            bad++;
            $error("FAIL %s cathodes got=%h want=%h", tag, bus.Cathodes, exp_cath);
        end
    endtask

    // Hold the engine and scan every digit, checking the pins against fixed expected values
    task automatic checkConst(input string tag, input logic [1:0] sel, input logic [15:0] want,
                              input logic [7:0] want_led);
        logic [7:0] exp_cath;
        applyStimulus(1'b0, 1'b1, sel);
        #1;
        for (int i = 0; i < 4 * SCAN_DIV; i++) begin
            exp_cath = SEG_TAB[(want >> (4 * model_dig())) & 16'hF];
            total++;
            assert (bus.Cathodes === exp_cath) else begin
                bad++;
                $error("FAIL %s digit%0d got=%h want=%h", tag, model_dig(), bus.Cathodes, exp_cath);
            end
            total++;
            assert (bus.LED === want_led) else begin
                bad++;
                $error("FAIL %s led got=%h want=%h", tag, bus.LED, want_led);
            end
            checkOutput(tag);
            tick();
        end
    endtask

    task automatic runUntil(input int target, input string tag);
        int n;
        int bound;
        n     = 0;
        bound = (target - model_steps()) * STEP_DIV * 2 + 100;
        while (model_steps() < target && n < bound) begin
            applyStimulus(1'b0, 1'b0, 2'($urandom_range(0, 3)));
            tick();
            checkOutput(tag);
            n++;
        end
        if (model_steps() < target) begin
            total++;
            bad++;
            $error("FAIL %s timeout got=%0d want=%0d", tag, model_steps(), target);
        end
    endtask

    logic [7:0] held_led;

    initial begin
        applyStimulus(1'b1, 1'b0, 2'b00);

        // Reset held for ten cycles
        for (int i = 0; i < 10; i++) begin
            tick();
            total++;
            assert (bus.LED === 8'h00 && bus.AN === 4'b1110 && bus.Cathodes === 8'hC0) else begin
                bad++;
                $error("FAIL reset pins got=%h/%b/%h want=00/1110/C0", bus.LED, bus.AN, bus.Cathodes);
            end
            checkOutput("reset");
        end

        // Release: the first step lands exactly STEP_DIV edges later
        applyStimulus(1'b0, 1'b0, 2'b00);
        for (int i = 1; i <= STEP_DIV; i++) begin
            tick();
            total++;
            assert (bus.LED === ((i == STEP_DIV) ? 8'h01 : 8'h00)) else begin
                bad++;
                $error("FAIL first_step edge%0d got=%h want=%h", i, bus.LED,
                       (i == STEP_DIV) ? 8'h01 : 8'h00);
            end
            checkOutput("first_step");
        end

        // 100 steps, then look at all four selections
        runUntil(100, "run100");
        checkConst("acc100", 2'b00, 16'h13BA, 8'h64);
        checkConst("cnt100", 2'b01, 16'h0064, 8'h64);
        checkConst("pc100", 2'b10, 16'h0064, 8'h64);
        checkConst("mix100", 2'b11, 16'h6464, 8'h64);

        // Hold in the middle of a count, then resume from the same divider position
        applyStimulus(1'b0, 1'b0, 2'b01);
        tick();
        tick();
        checkOutput("pre_hold");
        held_led = model_led();
        applyStimulus(1'b0, 1'b1, 2'b01);
        for (int i = 0; i < 50; i++) begin
            applyStimulus(1'b0, 1'b1, 2'($urandom_range(0, 3)));
            tick();
            total++;
            assert (bus.LED === held_led) else begin
                bad++;
                $error("FAIL hold_led got=%h want=%h", bus.LED, held_led);
            end
            checkOutput("hold");
        end
        applyStimulus(1'b0, 1'b0, 2'b01);
        tick();
        total++;
        assert (bus.LED === held_led) else begin
            bad++;
            $error("FAIL resume_early got=%h want=%h", bus.LED, held_led);
        end
        tick();
        total++;
        assert (bus.LED === held_led + 8'd1) else begin
            bad++;
            $error("FAIL resume_step got=%h want=%h", bus.LED, held_led + 8'd1);
        end
        checkOutput("resume");

        // Wrap-around checks
        runUntil(256, "run256");
        checkConst("cnt256", 2'b01, 16'h0100, 8'h00);
        runUntil(362, "run362");
        checkConst("acc362", 2'b00, 16'h00A7, 8'h6A);

        // Random hold and switch activity
        for (int i = 0; i < 600; i++) begin
            applyStimulus(1'b0, ($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)));
            tick();
            checkOutput("random");
        end

        // Reset in the middle of a run clears everything on the next edge
        applyStimulus(1'b1, 1'b0, 2'b00);
        tick();
        total++;
        assert (bus.LED === 8'h00 && bus.AN === 4'b1110 && bus.Cathodes === 8'hC0) else begin
            bad++;
            $error("FAIL midreset got=%h/%b/%h want=00/1110/C0", bus.LED, bus.AN, bus.Cathodes);
        end
        applyStimulus(1'b1, 1'b0, 2'b01);
        #1;
        total++;
        assert (bus.Cathodes === 8'hC0) else begin
            bad++;
            $error("FAIL midreset_cnt got=%h want=C0", bus.Cathodes);
        end
        applyStimulus(1'b0, 1'b0, 2'b00);
        for (int i = 0; i < 40; i++) begin
            tick();
            checkOutput("after_reset");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
